// File: rtl/ifetch_unit.sv
// ifetch_unit: PC register, req/ack instruction fetch, and an instruction register
// whose decoded fields are offered downstream over a valid/ready handshake.
`default_nettype none

module ifetch_unit #(
  parameter int                    PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [5:0]          op,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          rd,
  output logic [5:0]          funct,
  output logic [15:0]         imm,
  output logic [PC_WIDTH-1:0] pc_out,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [31:0]         ir_q, ir_d;

  // Branch targets are word-aligned by construction; the low bits are dropped.
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      ir_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      ir_q     <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    ir_d     = ir_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          ir_d     = imem_rdata;
          pc_out_d = pc_q;
          pc_d     = pc_q + PC_WIDTH'(4);
          state_d  = HOLD;
        end
      end
      HOLD: begin
        // A redirect only counts when the instruction is actually accepted.
        if (instr_ready) begin
          if (branch_taken) begin
            pc_d = {branch_target[PC_WIDTH-1:2], 2'b00};
          end
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req    = (state_q == FETCH);
  assign instr_valid = (state_q == HOLD);
  assign imem_addr   = pc_q;
  assign pc_out      = pc_out_q;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign funct = ir_q[5:0];
  assign imm   = ir_q[15:0];

endmodule

`default_nettype wire
